// File: rtl/rect_drag_ctl.sv
// Drag-and-drop for the rendered rectangle: debounced grab, cursor follow with edge clamping, drop strobe on release.
// Outputs registered (1-cycle latency); no backpressure, drop_pulse is a single-cycle strobe with drop_x/drop_y held.
module rect_drag_ctl #(
  parameter int RECT_W     = 48,
  parameter int RECT_H     = 64,
  parameter int H_MAX      = 800,
  parameter int V_MAX      = 600,
  parameter int DEB_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  input  logic        left_in,
  input  logic [11:0] xpos_ctl,
  input  logic [11:0] ypos_ctl,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out,
  output logic        dragging,
  output logic        drop_pulse,
  output logic [11:0] drop_x,
  output logic [11:0] drop_y
);

  localparam int                CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]     DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic signed [12:0] X_LIM   = 13'(H_MAX - RECT_W);
  localparam logic signed [12:0] Y_LIM   = 13'(V_MAX - RECT_H);

  typedef enum logic [1:0] {IDLE, GRAB, DRAG, DROP} state_t;

  state_t        state;
  logic          left_db;
  logic          left_db_q;
  logic [CW-1:0] deb_cnt;
  logic [11:0]   dx;
  logic [11:0]   dy;
  logic          rise;
  logic          in_rect;
  logic [12:0]   x_end;
  logic [12:0]   y_end;
  logic [11:0]   x_next;
  logic [11:0]   y_next;

  // Cursor minus grab offset, pinned so the rectangle stays fully on screen.
  function automatic logic [11:0] clamp_pos(input logic [11:0] pos, input logic [11:0] off,
                                            input logic signed [12:0] lim);
    logic signed [12:0] d;
    d = $signed({1'b0, pos}) - $signed({1'b0, off});
    if (d < 13'sd0)
      clamp_pos = 12'd0;
    else if (d > lim)
      clamp_pos = lim[11:0];
    else
      clamp_pos = d[11:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      left_db   <= 1'b0;
      left_db_q <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      left_db_q <= left_db;
      if (left_in == left_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        left_db <= left_in;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    rise    = left_db & ~left_db_q;
    x_end   = {1'b0, xpos_ctl} + 13'(RECT_W - 1);
    y_end   = {1'b0, ypos_ctl} + 13'(RECT_H - 1);
    in_rect = (xpos_in >= xpos_ctl) && ({1'b0, xpos_in} <= x_end) &&
              (ypos_in >= ypos_ctl) && ({1'b0, ypos_in} <= y_end);
    x_next  = clamp_pos(xpos_in, dx, X_LIM);
    y_next  = clamp_pos(ypos_in, dy, Y_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dx         <= 12'd0;
      dy         <= 12'd0;
      xpos_out   <= 12'd0;
      ypos_out   <= 12'd0;
      dragging   <= 1'b0;
      drop_pulse <= 1'b0;
      drop_x     <= 12'd0;
      drop_y     <= 12'd0;
    end else begin
      drop_pulse <= 1'b0;
      case (state)
        IDLE: begin
          xpos_out <= xpos_ctl;
          ypos_out <= ypos_ctl;
          if (rise && in_rect) begin
            dx       <= xpos_in - xpos_ctl;
            dy       <= ypos_in - ypos_ctl;
            dragging <= 1'b1;
            state    <= GRAB;
          end
        end
        GRAB: state <= DRAG;
        DRAG: begin
          // Level test so a release that landed during GRAB still ends the drag.
          if (!left_db) begin
            dragging   <= 1'b0;
            drop_pulse <= 1'b1;
            drop_x     <= xpos_out;
            drop_y     <= ypos_out;
            state      <= DROP;
          end else begin
            xpos_out <= x_next;
            ypos_out <= y_next;
          end
        end
        DROP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_drag_ctl.sv
// Randomised bench for rect_drag_ctl: behavioural model feeds per-cycle and drop-event scoreboards.
module tb_rect_drag_ctl;
  localparam int RW = 48, RH = 64, HM = 800, VM = 600, DEB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos_in, ypos_in, xpos_ctl, ypos_ctl;
  logic        left_in;
  logic [11:0] xpos_out, ypos_out, drop_x, drop_y;
  logic        dragging, drop_pulse;

  rect_drag_ctl #(.RECT_W(RW), .RECT_H(RH), .H_MAX(HM), .V_MAX(VM), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .xpos_in(xpos_in), .ypos_in(ypos_in), .left_in(left_in),
    .xpos_ctl(xpos_ctl), .ypos_ctl(ypos_ctl), .xpos_out(xpos_out), .ypos_out(ypos_out),
    .dragging(dragging), .drop_pulse(drop_pulse), .drop_x(drop_x), .drop_y(drop_y)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int dx; int dy; bit drg; bit pulse; } exp_t;
  typedef struct { int x; int y; } drop_t;

  exp_t  exp_q[$];
  drop_t drop_q[$];
  int    checks = 0, failures = 0;

  // Reference model: phase 0 free, 1 just grabbed, 2 held, 3 just dropped.
  int m_phase, m_offx, m_offy, m_outx, m_outy, m_dropx, m_dropy;
  bit m_db, m_db_prev, m_drg, m_pulse;
  bit hist[$];
  int cx, cy, ccx, ccy;
  bit cl;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input int xi, input int yi, input bit l, input int xc, input int yc);
    bit    rise, inr, steady;
    exp_t  e;
    drop_t d;
    @(negedge clk);
    rst = r; xpos_in = 12'(xi); ypos_in = 12'(yi); left_in = l;
    xpos_ctl = 12'(xc); ypos_ctl = 12'(yc);
    cx = xi; cy = yi; cl = l; ccx = xc; ccy = yc;
    if (r) begin
      m_phase = 0; m_offx = 0; m_offy = 0; m_outx = 0; m_outy = 0;
      m_dropx = 0; m_dropy = 0; m_db = 0; m_db_prev = 0; m_drg = 0; m_pulse = 0;
      hist.delete();
    end else begin
      rise    = m_db && !m_db_prev;
      m_pulse = 0;
      case (m_phase)
        0: begin
          m_outx = xc; m_outy = yc;
          inr = (xi >= xc) && (xi <= xc + RW - 1) && (yi >= yc) && (yi <= yc + RH - 1);
          if (rise && inr) begin
            m_offx = xi - xc; m_offy = yi - yc; m_phase = 1; m_drg = 1;
          end
        end
        1: m_phase = 2;
        2: begin
          if (!m_db) begin
            m_phase = 3; m_drg = 0; m_pulse = 1; m_dropx = m_outx; m_dropy = m_outy;
            d.x = m_outx; d.y = m_outy;
            drop_q.push_back(d);
          end else begin
            m_outx = clampi(xi - m_offx, 0, HM - RW);
            m_outy = clampi(yi - m_offy, 0, VM - RH);
          end
        end
        default: m_phase = 0;
      endcase
      // Button state flips once the last DEB samples all agree on the other level.
      hist.push_back(l);
      if (hist.size() > DEB) void'(hist.pop_front());
      m_db_prev = m_db;
      steady = (hist.size() == DEB);
      foreach (hist[i]) if (hist[i] == m_db) steady = 0;
      if (steady) m_db = !m_db;
    end
    e.x = m_outx; e.y = m_outy; e.dx = m_dropx; e.dy = m_dropy; e.drg = m_drg; e.pulse = m_pulse;
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n);
    repeat (n) step(1'b0, cx, cy, cl, ccx, ccy);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    exp_t  e;
    drop_t d;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("xpos_out", int'(xpos_out), e.x);
      chk("ypos_out", int'(ypos_out), e.y);
      chk("drop_x", int'(drop_x), e.dx);
      chk("drop_y", int'(drop_y), e.dy);
      chk("dragging", int'(dragging), int'(e.drg));
      chk("drop_pulse", int'(drop_pulse), int'(e.pulse));
    end
    if (drop_pulse === 1'b1) begin
      chk("drop_expected", int'(drop_q.size() > 0), 1);
      if (drop_q.size() > 0) begin
        d = drop_q.pop_front();
        chk("drop_event_x", int'(drop_x), d.x);
        chk("drop_event_y", int'(drop_y), d.y);
      end
    end
  end

  initial begin
    int xc, yc, xi, yi, n;
    rst = 1'b1; xpos_in = '0; ypos_in = '0; left_in = 1'b0; xpos_ctl = '0; ypos_ctl = '0;

    // Reset with every input nonzero, then release with ctl = (100,200).
    repeat (3) step(1'b1, 7, 9, 1'b1, 11, 13);
    settle();
    chk("rst_xpos", int'(xpos_out), 0);
    chk("rst_ypos", int'(ypos_out), 0);
    chk("rst_dragging", int'(dragging), 0);
    chk("rst_drop_pulse", int'(drop_pulse), 0);
    repeat (2) step(1'b0, 50, 60, 1'b0, 100, 200);
    settle();
    chk("post_rst_x", int'(xpos_out), 100);
    chk("post_rst_y", int'(ypos_out), 200);

    // Grab at (120,230): offset (20,30).
    repeat (2) step(1'b0, 120, 230, 1'b0, 100, 200);
    repeat (20) step(1'b0, 120, 230, 1'b1, 100, 200);
    settle();
    chk("grab_dragging", int'(dragging), 1);
    repeat (2) step(1'b0, 300, 400, 1'b1, 100, 200);
    settle();
    chk("drag_x", int'(xpos_out), 280);
    chk("drag_y", int'(ypos_out), 370);

    // Clamping at both screen edges.
    repeat (2) step(1'b0, 5, 5, 1'b1, 100, 200);
    settle();
    chk("clamp_lo_x", int'(xpos_out), 0);
    chk("clamp_lo_y", int'(ypos_out), 0);
    repeat (2) step(1'b0, 799, 599, 1'b1, 100, 200);
    settle();
    chk("clamp_hi_x", int'(xpos_out), 752);
    chk("clamp_hi_y", int'(ypos_out), 536);

    // One cycle short of the debounce window is ignored; a full window drops.
    repeat (DEB - 1) step(1'b0, 799, 599, 1'b0, 100, 200);
    repeat (5) step(1'b0, 799, 599, 1'b1, 100, 200);
    settle();
    chk("glitch_dragging", int'(dragging), 1);
    repeat (DEB + 4) step(1'b0, 799, 599, 1'b0, 100, 200);
    settle();
    chk("dropped_x", int'(drop_x), 752);
    chk("dropped_y", int'(drop_y), 536);
    chk("after_drop_x", int'(xpos_out), 100);
    chk("after_drop_dragging", int'(dragging), 0);

    // Press outside the rectangle: no grab, outputs keep tracking ctl.
    repeat (40) step(1'b0, 50, 50, 1'b1, 100, 200);
    settle();
    chk("miss_dragging", int'(dragging), 0);
    chk("miss_x", int'(xpos_out), 100);
    repeat (2) step(1'b0, 50, 50, 1'b1, 130, 210);
    settle();
    chk("miss_track_y", int'(ypos_out), 210);
    repeat (20) step(1'b0, 50, 50, 1'b0, 130, 210);

    // Reset in the middle of a drag.
    repeat (20) step(1'b0, 110, 210, 1'b1, 100, 200);
    settle();
    chk("pre_rst_dragging", int'(dragging), 1);
    step(1'b1, 110, 210, 1'b0, 100, 200);
    settle();
    chk("mid_rst_dragging", int'(dragging), 0);
    chk("mid_rst_x", int'(xpos_out), 0);
    chk("mid_rst_pulse", int'(drop_pulse), 0);
    repeat (3) step(1'b0, 110, 210, 1'b0, 100, 200);

    // Random episodes: press, wander (with glitches, ctl noise, occasional reset), release.
    for (int ep = 0; ep < 40; ep++) begin
      if ($urandom_range(0, 7) == 0) begin
        xc = $urandom_range(0, 4095); yc = $urandom_range(0, 4095);
      end else begin
        xc = $urandom_range(0, 760); yc = $urandom_range(0, 540);
      end
      if ($urandom_range(0, 3) == 0) begin
        xi = $urandom_range(0, 1023); yi = $urandom_range(0, 1023);
      end else begin
        xi = clampi(xc + $urandom_range(0, RW - 1), 0, 4095);
        yi = clampi(yc + $urandom_range(0, RH - 1), 0, 4095);
      end
      n = $urandom_range(DEB, DEB + 6);
      repeat (n) step(1'b0, xi, yi, 1'b1, xc, yc);
      n = $urandom_range(5, 30);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 9) == 0) begin
          xi = $urandom_range(0, 4095); yi = $urandom_range(0, 4095);
        end else begin
          xi = $urandom_range(0, 1023); yi = $urandom_range(0, 1023);
        end
        step(1'b0, xi, yi, 1'b1, $urandom_range(0, 4095), $urandom_range(0, 4095));
        if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, DEB - 1)) step(1'b0, xi, yi, 1'b0, ccx, ccy);
        if ($urandom_range(0, 60) == 0) step(1'b1, xi, yi, 1'b1, ccx, ccy);
      end
      repeat ($urandom_range(DEB + 2, DEB + 8)) step(1'b0, xi, yi, 1'b0, $urandom_range(0, 4095), $urandom_range(0, 4095));
      repeat ($urandom_range(2, 6)) step(1'b0, xi, yi, 1'b0, $urandom_range(0, 800), $urandom_range(0, 600));
    end

    repeat (3) @(posedge clk);
    #3;
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("drop_queue_drained", drop_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rect_drag_ctl.md
Name: rect_drag_ctl

Overview:
Mouse drag-and-drop controller in the pclk domain, sitting directly upstream of draw_rect. It takes the clk100→pclk synchronised mouse position and button, plus the rectangle position from the fall/bounce controller. It outputs the rectangle position that draw_rect renders. When the user grabs the rectangle with the left button, the rectangle follows the cursor; on release it emits a one-cycle drop event so the bounce controller restarts from the drop point.

Parameters:
RECT_W, 48, rectangle width in pixels
RECT_H, 64, rectangle height in pixels
H_MAX, 800, visible horizontal pixels
V_MAX, 600, visible vertical pixels
DEB_CYCLES, 16, cycles left_in must be stable before the debounced button changes

Ports:
clk  input  1  pixel clock (pclk, 40 MHz)
rst  input  1  synchronous reset, active-high
xpos_in  input  12  cursor x, already synchronised to clk
ypos_in  input  12  cursor y, already synchronised to clk
left_in  input  1  left button, already synchronised to clk
xpos_ctl  input  12  rectangle x from bounce controller
ypos_ctl  input  12  rectangle y from bounce controller
xpos_out  output  12  rectangle x to draw_rect
ypos_out  output  12  rectangle y to draw_rect
dragging  output  1  high while the rectangle is held
drop_pulse  output  1  one-cycle strobe on release
drop_x  output  12  x at release, valid with drop_pulse, held until next drop
drop_y  output  12  y at release, valid with drop_pulse, held until next drop

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - State IDLE; left_db=0; debounce counter=0; dx=dy=0.
  - All outputs 0.
  - Reset mid-drag returns to IDLE with no drop_pulse.
- Debounce:
  - The counter increments while left_in != left_db and clears when they are equal.
  - When the counter reaches DEB_CYCLES-1, left_db takes left_in on the next edge and the counter clears.
  - Glitches shorter than DEB_CYCLES are ignored.
  - Rise and fall are single-cycle pulses derived from left_db versus its previous value.
- Inside test (combinational on current inputs): xpos_ctl <= xpos_in <= xpos_ctl+RECT_W-1 and ypos_ctl <= ypos_in <= ypos_ctl+RECT_H-1. Sums are 13-bit, so there is no wrap.
- FSM states and transitions:
  - IDLE:
    - xpos_out/ypos_out register xpos_ctl/ypos_ctl (1-cycle latency); dragging=0.
    - On rise with inside true → GRAB; on rise with inside false → stay in IDLE.
  - GRAB (exactly 1 cycle):
    - Latch dx=xpos_in−xpos_ctl and dy=ypos_in−ypos_ctl, using the values sampled on the rise cycle.
    - Outputs hold the last values; dragging=1.
    - → DRAG.
  - DRAG:
    - dragging=1.
    - xpos_out = clamp(xpos_in−dx, 0, H_MAX−RECT_W) and ypos_out = clamp(ypos_in−dy, 0, V_MAX−RECT_H), registered with 1-cycle latency.
    - Subtraction is 13-bit signed; a negative result gives 0.
    - On fall → DROP.
  - DROP (1 cycle):
    - drop_pulse=1; drop_x/drop_y load the current xpos_out/ypos_out; outputs hold; dragging=0.
    - → IDLE.
- A rise during DRAG cannot occur, because left_db is already high. A fall in IDLE or GRAB is ignored; a fall in GRAB still proceeds to DRAG, then DROP.
- drop_pulse is never asserted in two consecutive cycles.
- Inputs xpos_ctl/ypos_ctl are ignored outside IDLE.

Test Plan:
- Reset: hold rst 3 cycles with all inputs nonzero → all outputs 0, dragging=0, drop_pulse=0. Release with ctl=(100,200) → outputs (100,200) on the 2nd edge after release.
- Grab and drag: ctl=(100,200), cursor (120,230), left_in high ≥DEB_CYCLES → GRAB then DRAG, dx=20, dy=30. Move cursor to (300,400) → outputs (280,370) one cycle later.
- Clamp: while dragging, cursor (5,5) → outputs (0,0). Cursor (799,599) → outputs (752,536).
- Miss: ctl=(100,200), cursor (50,50), button held 40 cycles → stays IDLE, dragging=0, outputs track ctl.
- Debounce: while dragging, left_in low for DEB_CYCLES−1 cycles then high → no drop. Low for DEB_CYCLES cycles → exactly one drop_pulse, drop_x/drop_y equal the last output, then outputs follow ctl.
- Reset mid-drag: assert rst during DRAG → IDLE next cycle, no drop_pulse, outputs 0.
